// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// master = controller (drives enables/selects), slave = datapath (drives IR fields, Zero).
interface multicycle_control_unit_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       MemToReg;
    logic [1:0] RegDst;
    logic       RegWrite;
    logic       JAL;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       shift;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       InstrDone;
    logic       Halted;

    modport master (
        input  Opcode, Funct, Zero,
        output IorD, IRWrite, MemWrite, MemToReg, RegDst, RegWrite, JAL,
               ALUSrcA, ALUSrcB, ALUControl, shift, PCSrc, PCEn, InstrDone, Halted
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  IorD, IRWrite, MemWrite, MemToReg, RegDst, RegWrite, JAL,
               ALUSrcA, ALUSrcB, ALUControl, shift, PCSrc, PCEn, InstrDone, Halted
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences a shared ALU and unified memory over
// several cycles per instruction. Control outputs are registered from the next
// state; PCEn additionally folds in Zero for branches.
module multicycle_control_unit #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic clk,
    input  logic reset,
    multicycle_control_unit_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
        BRANCH, ADDIEX, ADDIWB, JUMP, JALS, JR, HALT
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       jal;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       shift;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       instr_done;
        logic       halted;
    } ctl_t;

    state_t     state, state_next;
    ctl_t       ctl_q, ctl, fetch_ctl;
    logic [4:0] fn_dec;
    logic       decode_illegal;

    // R-type funct decode packed as {legal, shift, alu_control}
    function automatic logic [4:0] funct_decode(input logic [5:0] fn);
        case (fn)
            6'b100000: return {2'b10, ALU_ADD};
            6'b100010: return {2'b10, ALU_SUB};
            6'b100100: return {2'b10, ALU_AND};
            6'b100101: return {2'b10, ALU_OR};
            6'b101010: return {2'b10, ALU_SLT};
            6'b000000: return {2'b11, ALU_SLL};
            6'b000010: return {2'b11, ALU_SRL};
            default:   return 5'b00000;
        endcase
    endfunction

    // Moore control word of each state (IR fields refine EXEC and BRANCH)
    function automatic ctl_t state_ctl(input state_t s, input logic [5:0] op,
                                       input logic [5:0] fn);
        ctl_t       c;
        logic [4:0] fd;
        c  = '0;
        fd = funct_decode(fn);
        case (s)
            FETCH:  begin c.ir_write = 1'b1; c.alu_src_b = 2'b01;
                          c.alu_control = ALU_ADD; c.pc_write = 1'b1; end
            DECODE: begin c.alu_src_b = 2'b11; c.alu_control = ALU_ADD; end
            MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = ALU_ADD; end
            MEMRD:  c.iord = 1'b1;
            MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
            MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; end
            EXEC:   begin c.alu_src_a = 1'b1; c.alu_control = fd[2:0]; c.shift = fd[3];
                          c.instr_done = ~fd[4] & ~ILLEGAL_TRAP; end
            ALUWB:  begin c.reg_dst = 2'b01; c.reg_write = 1'b1; c.instr_done = 1'b1; end
            BRANCH: begin c.alu_src_a = 1'b1; c.alu_control = ALU_SUB; c.pc_src = 2'b01;
                          c.branch_eq = (op == OP_BEQ); c.branch_ne = (op == OP_BNE);
                          c.instr_done = 1'b1; end
            ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = ALU_ADD; end
            ADDIWB: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; end
            JALS:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.reg_dst = 2'b10; c.jal = 1'b1;
                          c.reg_write = 1'b1; c.instr_done = 1'b1; end
            JR:     begin c.pc_src = 2'b11; c.pc_write = 1'b1; c.instr_done = 1'b1; end
            HALT:   c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; unknown encodings fall back to FETCH
    always_comb begin
        state_next     = FETCH;
        decode_illegal = 1'b0;
        fn_dec         = funct_decode(bus.Funct);
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: case (bus.Opcode)
                OP_LW, OP_SW:   state_next = MEMADR;
                OP_RTYPE:       state_next = (bus.Funct == FN_JR) ? JR : EXEC;
                OP_BEQ, OP_BNE: state_next = BRANCH;
                OP_ADDI:        state_next = ADDIEX;
                OP_J:           state_next = JUMP;
                OP_JAL:         state_next = JALS;
                default: begin
                    decode_illegal = 1'b1;
                    state_next     = ILLEGAL_TRAP ? HALT : FETCH;
                end
            endcase
            MEMADR: state_next = (bus.Opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_next = MEMWB;
            EXEC:   state_next = fn_dec[4] ? ALUWB : (ILLEGAL_TRAP ? HALT : FETCH);
            ADDIEX: state_next = ADDIWB;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // State and registered control word; reset lands in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ctl_q <= state_ctl(FETCH, bus.Opcode, bus.Funct);
        end else begin
            state <= state_next;
            ctl_q <= state_ctl(state_next, bus.Opcode, bus.Funct);
        end
    end

    // While reset is high, present FETCH selects regardless of the current state
    always_comb begin
        fetch_ctl = state_ctl(FETCH, bus.Opcode, bus.Funct);
        ctl       = reset ? fetch_ctl : ctl_q;
    end

    assign bus.IorD       = ctl.iord;
    assign bus.MemToReg   = ctl.mem_to_reg;
    assign bus.RegDst     = ctl.reg_dst;
    assign bus.JAL        = ctl.jal;
    assign bus.ALUSrcA    = ctl.alu_src_a;
    assign bus.ALUSrcB    = ctl.alu_src_b;
    assign bus.ALUControl = ctl.alu_control;
    assign bus.shift      = ctl.shift;
    assign bus.PCSrc      = ctl.pc_src;
    assign bus.Halted     = ctl.halted;
    assign bus.IRWrite    = ctl.ir_write  & ~reset;
    assign bus.MemWrite   = ctl.mem_write & ~reset;
    assign bus.RegWrite   = ctl.reg_write & ~reset;
    assign bus.PCEn       = ~reset & (ctl.pc_write | (ctl.branch_eq & bus.Zero)
                                                   | (ctl.branch_ne & ~bus.Zero));
    // Opcode is only valid once DECODE is entered, so the illegal-opcode retire
    // pulse is decoded live rather than registered with the rest.
    assign bus.InstrDone  = ~reset & (ctl.instr_done
                                      | ((state == DECODE) & decode_illegal & ~ILLEGAL_TRAP));
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (no-trap and trap) share the
// same stimulus and are compared each cycle against a per-instruction model.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if bus0 ();
    multicycle_control_unit_if bus1 ();

    assign bus0.Opcode = opcode;
    assign bus0.Funct  = funct;
    assign bus0.Zero   = zero;
    assign bus1.Opcode = opcode;
    assign bus1.Funct  = funct;
    assign bus1.Zero   = zero;

    multicycle_control_unit #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    multicycle_control_unit #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct packed {
        logic       IorD, IRWrite, MemWrite, MemToReg;
        logic [1:0] RegDst;
        logic       RegWrite, JAL, ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] ALUControl;
        logic       shift;
        logic [1:0] PCSrc;
        logic       PCEn, InstrDone, Halted;
    } ctl_t;

    ctl_t obs0, obs1;
    assign obs0 = {bus0.IorD, bus0.IRWrite, bus0.MemWrite, bus0.MemToReg, bus0.RegDst,
                   bus0.RegWrite, bus0.JAL, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUControl,
                   bus0.shift, bus0.PCSrc, bus0.PCEn, bus0.InstrDone, bus0.Halted};
    assign obs1 = {bus1.IorD, bus1.IRWrite, bus1.MemWrite, bus1.MemToReg, bus1.RegDst,
                   bus1.RegWrite, bus1.JAL, bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUControl,
                   bus1.shift, bus1.PCSrc, bus1.PCEn, bus1.InstrDone, bus1.Halted};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, JAL = 6'b000011,
                           BAD = 6'b111111;

    function automatic bit op_legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, BNE, ADDI, J, JAL};
    endfunction

    // funct -> ALU operation; returns 0 when the funct is not an ALU R-type
    function automatic bit alu_of(input logic [5:0] fn, output logic [2:0] alu, output logic sh);
        sh = 1'b0;
        alu = 3'b000;
        case (fn)
            6'b100000: alu = 3'b010;
            6'b100010: alu = 3'b110;
            6'b100100: alu = 3'b000;
            6'b100101: alu = 3'b001;
            6'b101010: alu = 3'b111;
            6'b000000: begin alu = 3'b100; sh = 1'b1; end
            6'b000010: begin alu = 3'b101; sh = 1'b1; end
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // Cycles from FETCH through the retire cycle (no-trap instance)
    function automatic int instr_len(input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] a; logic s;
        if (!op_legal(op)) return 2;
        case (op)
            LW:       return 5;
            SW, ADDI: return 4;
            RT:       return (fn == 6'b001000) ? 3 : (alu_of(fn, a, s) ? 4 : 3);
            default:  return 3;
        endcase
    endfunction

    function automatic ctl_t reset_ctl();
        ctl_t c = '0;
        c.ALUSrcB = 2'b01; c.ALUControl = 3'b010;
        return c;
    endfunction

    // Expected outputs in cycle k of an instruction (k=0 is FETCH)
    function automatic ctl_t model(input logic [5:0] op, input logic [5:0] fn, input int k,
                                   input logic z, input bit trap);
        ctl_t c = '0;
        logic [2:0] alu; logic sh; bit fok;
        fok = alu_of(fn, alu, sh);
        if (k == 0) begin
            c.IRWrite = 1; c.ALUSrcB = 2'b01; c.ALUControl = 3'b010; c.PCEn = 1;
            return c;
        end
        if (k == 1) begin
            c.ALUSrcB = 2'b11; c.ALUControl = 3'b010;
            c.InstrDone = !op_legal(op) && !trap;
            return c;
        end
        if (!op_legal(op)) begin c.Halted = trap; return c; end
        case (op)
            LW: if (k == 2) begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUControl = 3'b010; end
                else if (k == 3) c.IorD = 1;
                else begin c.MemToReg = 1; c.RegWrite = 1; c.InstrDone = 1; end
            SW: if (k == 2) begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUControl = 3'b010; end
                else begin c.IorD = 1; c.MemWrite = 1; c.InstrDone = 1; end
            RT: if (fn == 6'b001000) begin c.PCSrc = 2'b11; c.PCEn = 1; c.InstrDone = 1; end
                else if (k == 2) begin
                    c.ALUSrcA = 1;
                    if (fok) begin c.ALUControl = alu; c.shift = sh; end
                    else c.InstrDone = !trap;
                end
                else if (fok) begin c.RegDst = 2'b01; c.RegWrite = 1; c.InstrDone = 1; end
                else c.Halted = trap;
            BEQ, BNE: begin
                c.ALUSrcA = 1; c.ALUControl = 3'b110; c.PCSrc = 2'b01; c.InstrDone = 1;
                c.PCEn = (op == BEQ) ? z : !z;
            end
            ADDI: if (k == 2) begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUControl = 3'b010; end
                  else begin c.RegWrite = 1; c.InstrDone = 1; end
            J:   begin c.PCSrc = 2'b10; c.PCEn = 1; c.InstrDone = 1; end
            default: begin
                c.PCSrc = 2'b10; c.PCEn = 1; c.RegDst = 2'b10; c.JAL = 1;
                c.RegWrite = 1; c.InstrDone = 1;
            end
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One cycle: drive Zero, then compare both instances (dut0 at k0, dut1 at k1)
    task automatic step(input string tag, input int k0, input int k1, input int zmode);
        zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
        #1;
        check($sformatf("%s dut0 k%0d", tag, k0), obs0, model(opcode, funct, k0, zero, 1'b0));
        check($sformatf("%s dut1 k%0d", tag, k1), obs1, model(opcode, funct, k1, zero, 1'b1));
        @(posedge clk); #1;
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input int zmode);
        opcode = op; funct = fn;
        for (int k = 0; k < instr_len(op, fn); k++) step(tag, k, k, zmode);
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        zero = 1'($urandom);
        #1;
        check({tag, " dut0"}, obs0, reset_ctl());
        check({tag, " dut1"}, obs1, reset_ctl());
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] rop, rfn;
        reset = 1'b1; opcode = LW; funct = 6'd0; zero = 1'b0;
        #1;
        check("rst0 dut0", obs0, reset_ctl());
        check("rst0 dut1", obs1, reset_ctl());
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst%0d dut0", i + 1), obs0, reset_ctl());
            check($sformatf("rst%0d dut1", i + 1), obs1, reset_ctl());
        end
        reset = 1'b0;

        run("lw",      LW,   6'd0,      -1);
        run("sw",      SW,   6'd0,      -1);
        run("sub",     RT,   6'b100010, -1);
        run("sll",     RT,   6'b000000, -1);
        run("beq z1",  BEQ,  6'd0,       1);
        run("beq z0",  BEQ,  6'd0,       0);
        run("bne z0",  BNE,  6'd0,       0);
        run("bne z1",  BNE,  6'd0,       1);
        run("jal",     JAL,  6'd0,      -1);
        run("jr",      RT,   6'b001000, -1);
        run("addi",    ADDI, 6'd0,      -1);
        run("j",       J,    6'd0,      -1);

        for (int i = 0; i < 30; i++) begin
            rfn = 6'($urandom);
            case ($urandom_range(0, 14))
                0: rop = LW;    1: rop = SW;    2: begin rop = RT; rfn = 6'b100000; end
                3: begin rop = RT; rfn = 6'b100010; end
                4: begin rop = RT; rfn = 6'b100100; end
                5: begin rop = RT; rfn = 6'b100101; end
                6: begin rop = RT; rfn = 6'b101010; end
                7: begin rop = RT; rfn = 6'b000000; end
                8: begin rop = RT; rfn = 6'b000010; end
                9: rop = BEQ;  10: rop = BNE;  11: rop = ADDI;  12: rop = J;  13: rop = JAL;
                default: begin rop = RT; rfn = 6'b001000; end
            endcase
            run($sformatf("rand%0d", i), rop, rfn, -1);
        end

        // illegal opcode: dut0 retires as NOP and keeps cycling, dut1 halts
        opcode = BAD; funct = 6'($urandom);
        step("badop", 0, 0, -1);
        step("badop", 1, 1, -1);
        for (int i = 0; i < 12; i++) step("halt", i % 2, 2 + i, -1);

        // mid-instruction reset during sw: no write, back to FETCH
        reset_pulse("rst halt");
        opcode = SW; funct = 6'd0;
        for (int k = 0; k < 3; k++) step("sw part", k, k, -1);
        reset_pulse("rst mid-sw");
        run("addi post", ADDI, 6'd0, -1);

        // illegal R-type funct
        opcode = RT; funct = 6'b111111;
        for (int k = 0; k < 3; k++) step("badfn", k, k, -1);
        for (int i = 0; i < 4; i++) step("badfn halt", i % 3, 3 + i, -1);
        reset_pulse("rst badfn");
        run("lw post", LW, 6'd0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
FSM controller that sequences a multicycle variant of the MIPS datapath. One shared ALU and one unified memory are reused across several cycles per instruction. It decodes the same instruction subset and ALUControl/shift encoding as the single-cycle control path. All datapath enables and mux selects are Moore outputs of the state register; only PCEn also depends on Zero. It sits beside the datapath and replaces the single-cycle control unit in the multicycle top level.

Parameters:
ILLEGAL_TRAP, 0, 0: an unknown opcode or R-type funct retires as a NOP; 1: it enters HALT until reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Opcode  in  6  IR[31:26], valid from DECODE onward
Funct  in  6  IR[5:0], valid from DECODE onward
Zero  in  1  ALU zero flag
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
IRWrite  out  1  load IR
MemWrite  out  1  memory write strobe
MemToReg  out  1  register-file write data: 0 = ALUOut, 1 = MDR
RegDst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31
RegWrite  out  1  register-file write enable
JAL  out  1  register-file write data forced to PC (overrides MemToReg)
ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A
ALUSrcB  out  2  ALU B input: 00 = register B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
ALUControl  out  3  and 000, or 001, add 010, sll 100, srl 101, sub 110, slt 111
shift  out  1  ALU A input uses shamt
PCSrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A
PCEn  out  1  PC load enable
InstrDone  out  1  one-cycle pulse in the last cycle of each instruction
Halted  out  1  high while in HALT

Behaviour:
- State register updates on the rising edge of clk. If reset=1 at an edge, next state is FETCH.
- While reset=1, all write-type outputs are forced 0: IRWrite, MemWrite, RegWrite, PCEn, InstrDone. Other outputs take their FETCH values.
- Every output not listed for a state is 0 in that state.
- PCEn = PCWrite | (BranchEq & Zero) | (BranchNe & ~Zero). PCWrite, BranchEq and BranchNe are internal.
- FETCH: IRWrite=1, ALUSrcB=01, ALUControl=add, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcB=11, ALUControl=add (computes branch target). Next state by opcode:
  - lw 100011 / sw 101011 -> MEMADR
  - R-type 000000 -> JR if funct 001000, else EXEC
  - beq 000100 / bne 000101 -> BRANCH
  - addi 001000 -> ADDIEX
  - j 000010 -> JUMP
  - jal 000011 -> JALS
  - anything else -> FETCH with InstrDone=1 (ILLEGAL_TRAP=0), or HALT (ILLEGAL_TRAP=1)
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1. Next state MEMWB.
- MEMWB: RegDst=00, MemToReg=1, RegWrite=1, InstrDone=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1, InstrDone=1. Next state FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - 000000 sll and 000010 srl also set shift=1
  - any other funct is illegal: handled as in DECODE, with no register write
- ALUWB: RegDst=01, RegWrite=1, InstrDone=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. BranchEq set for beq, BranchNe set for bne. InstrDone=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Next state ADDIWB.
- ADDIWB: RegDst=00, RegWrite=1, InstrDone=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1, InstrDone=1. Next state FETCH.
- JALS: PCSrc=10, PCWrite=1, RegDst=10, JAL=1, RegWrite=1, InstrDone=1. The register file writes the PC, which is already PC+4 from FETCH. Next state FETCH.
- JR: PCSrc=11, PCWrite=1, InstrDone=1. Next state FETCH.
- HALT: Halted=1, all enables 0. Only reset exits.
- Cycle counts (FETCH through the InstrDone cycle): lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jal/jr 3, illegal 2.
- Reset asserted mid-instruction: no write occurs in that cycle, and the next state is FETCH.
- Encoding: the state register holds at most 4 bits. Unreachable encodings recover to FETCH.

Test Plan:
- Reset held 2 cycles, then released with Opcode=100011 -> outputs during reset: IRWrite=PCEn=0; states after release: FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemToReg=1 only in cycle 5; InstrDone pulses once.
- sw (101011) -> MemWrite=1 with IorD=1 in cycle 4 only; RegWrite never asserts.
- R-type funct 100010 -> ALUControl=110 in EXEC; ALUWB has RegDst=01, RegWrite=1. Repeat with funct 000000 -> shift=1, ALUControl=100.
- beq with Zero=1 -> PCEn=1 in cycle 3. beq with Zero=0 -> PCEn=0. bne with Zero=0 -> PCEn=1. Each takes 3 cycles.
- jal then jr (R-type, funct 001000) -> jal cycle 3: RegDst=10, JAL=1, RegWrite=1, PCSrc=10. jr cycle 3: PCSrc=11, PCEn=1, RegWrite=0.
- Opcode 111111: with ILLEGAL_TRAP=0 -> back to FETCH after 2 cycles, no writes. With ILLEGAL_TRAP=1 -> Halted=1 held for 10+ cycles; a reset pulse returns the FSM to FETCH.
